// File: rtl/armleo_axi_read_demux_if.sv
// AXI4 read-channel bundle carrying N lanes packed side by side.
// One lane for the upstream host port, CLIENT_NUMBER lanes for the fan-out side.
interface armleo_axi_read_demux_if #(
    parameter int N          = 1,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    logic [N-1:0]            arvalid;
    logic [N-1:0]            arready;
    logic [N*ADDR_WIDTH-1:0] araddr;
    logic [N*8-1:0]          arlen;
    logic [N*3-1:0]          arsize;
    logic [N*2-1:0]          arburst;
    logic [N*ID_WIDTH-1:0]   arid;
    logic [N-1:0]            arlock;
    logic [N*3-1:0]          arprot;

    logic [N-1:0]            rvalid;
    logic [N-1:0]            rready;
    logic [N*2-1:0]          rresp;
    logic [N-1:0]            rlast;
    logic [N*DATA_WIDTH-1:0] rdata;
    logic [N*ID_WIDTH-1:0]   rid;

    modport master (
        output arvalid, araddr, arlen, arsize, arburst, arid, arlock, arprot, rready,
        input  arready, rvalid, rresp, rlast, rdata, rid
    );

    modport slave (
        input  arvalid, araddr, arlen, arsize, arburst, arid, arlock, arprot, rready,
        output arready, rvalid, rresp, rlast, rdata, rid
    );
endinterface

// File: rtl/armleo_axi_read_demux.sv
// Routes one AXI4 read host to one of CLIENT_NUMBER clients by address decode,
// one burst at a time; unmapped addresses are answered with a local DECERR burst.
module armleo_axi_read_demux #(
    parameter int CLIENT_NUMBER = 4,
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int ID_WIDTH      = 4,
    parameter logic [CLIENT_NUMBER*ADDR_WIDTH-1:0] CLIENT_BASE = '0,
    parameter logic [CLIENT_NUMBER*ADDR_WIDTH-1:0] CLIENT_MASK = '0,
    localparam int CLIENT_NUMBER_CLOG2 = $clog2(CLIENT_NUMBER)
) (
    input logic clk,
    input logic rst,
    armleo_axi_read_demux_if.slave  upstream_axi,
    armleo_axi_read_demux_if.master downstream_axi
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FWD_R = 2'd1,
        ERR_R = 2'd2
    } state_t;

    state_t                         state_q, state_d;
    logic [CLIENT_NUMBER_CLOG2-1:0] sel_q, sel_d;
    logic [ID_WIDTH-1:0]            err_id_q, err_id_d;
    logic [7:0]                     err_len_q, err_len_d;
    logic [7:0]                     beat_cnt_q, beat_cnt_d;

    logic                           hit;
    logic [CLIENT_NUMBER_CLOG2-1:0] hit_idx;

    logic                           up_arready;
    logic                           up_rvalid;
    logic [1:0]                     up_rresp;
    logic                           up_rlast;
    logic [DATA_WIDTH-1:0]          up_rdata;
    logic [ID_WIDTH-1:0]            up_rid;
    logic [CLIENT_NUMBER-1:0]       ds_arvalid;
    logic [CLIENT_NUMBER-1:0]       ds_rready;

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = CLIENT_NUMBER - 1; i >= 0; i--) begin
            if ((upstream_axi.araddr & CLIENT_MASK[i*ADDR_WIDTH +: ADDR_WIDTH])
                    == CLIENT_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                hit     = 1'b1;
                hit_idx = CLIENT_NUMBER_CLOG2'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        err_id_d   = err_id_q;
        err_len_d  = err_len_q;
        beat_cnt_d = beat_cnt_q;
        up_arready = 1'b0;
        up_rvalid  = 1'b0;
        up_rresp   = 2'b00;
        up_rlast   = 1'b0;
        up_rdata   = '0;
        up_rid     = '0;
        ds_arvalid = '0;
        ds_rready  = '0;

        unique case (state_q)
            IDLE: begin
                if (hit) begin
                    ds_arvalid[hit_idx] = upstream_axi.arvalid;
                    up_arready          = downstream_axi.arready[hit_idx];
                    if (upstream_axi.arvalid && downstream_axi.arready[hit_idx]) begin
                        sel_d   = hit_idx;
                        state_d = FWD_R;
                    end
                end else if (upstream_axi.arvalid) begin
                    up_arready = 1'b1;
                    err_id_d   = upstream_axi.arid;
                    err_len_d  = upstream_axi.arlen;
                    beat_cnt_d = '0;
                    state_d    = ERR_R;
                end
            end

            FWD_R: begin
                up_rvalid        = downstream_axi.rvalid[sel_q];
                up_rresp         = downstream_axi.rresp[int'(sel_q)*2 +: 2];
                up_rlast         = downstream_axi.rlast[sel_q];
                up_rdata         = downstream_axi.rdata[int'(sel_q)*DATA_WIDTH +: DATA_WIDTH];
                up_rid           = downstream_axi.rid[int'(sel_q)*ID_WIDTH +: ID_WIDTH];
                ds_rready[sel_q] = upstream_axi.rready;
                if (up_rvalid && upstream_axi.rready && up_rlast) begin
                    state_d = IDLE;
                end
            end

            ERR_R: begin
                up_rvalid = 1'b1;
                up_rresp  = 2'b11;
                up_rid    = err_id_q;
                up_rlast  = (beat_cnt_q == err_len_q);
                // Counter wraps only on the 256th beat, which is also the exit.
                if (upstream_axi.rready) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (up_rlast) begin
                        state_d = IDLE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        if (rst) begin
            up_arready = 1'b0;
            up_rvalid  = 1'b0;
            up_rresp   = 2'b00;
            up_rlast   = 1'b0;
            up_rdata   = '0;
            up_rid     = '0;
            ds_arvalid = '0;
            ds_rready  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Captured DECERR attributes are only meaningful once ERR_R is entered.
    always_ff @(posedge clk) begin
        err_id_q  <= err_id_d;
        err_len_q <= err_len_d;
    end

    assign upstream_axi.arready = up_arready;
    assign upstream_axi.rvalid  = up_rvalid;
    assign upstream_axi.rresp   = up_rresp;
    assign upstream_axi.rlast   = up_rlast;
    assign upstream_axi.rdata   = up_rdata;
    assign upstream_axi.rid     = up_rid;

    assign downstream_axi.arvalid = ds_arvalid;
    assign downstream_axi.rready  = ds_rready;
    assign downstream_axi.araddr  = {CLIENT_NUMBER{upstream_axi.araddr}};
    assign downstream_axi.arlen   = {CLIENT_NUMBER{upstream_axi.arlen}};
    assign downstream_axi.arsize  = {CLIENT_NUMBER{upstream_axi.arsize}};
    assign downstream_axi.arburst = {CLIENT_NUMBER{upstream_axi.arburst}};
    assign downstream_axi.arid    = {CLIENT_NUMBER{upstream_axi.arid}};
    assign downstream_axi.arlock  = {CLIENT_NUMBER{upstream_axi.arlock}};
    assign downstream_axi.arprot  = {CLIENT_NUMBER{upstream_axi.arprot}};

endmodule

// File: tb/tb_armleo_axi_read_demux.sv
// Directed bench for armleo_axi_read_demux: routing, DECERR, backpressure,
// client exclusivity, maximum burst length, overlapping regions and reset.
module tb_armleo_axi_read_demux;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;

    // Client 1 sits at 0x12000; client 2 ignores upper address bits, so 0x12xxx overlaps both.
    localparam logic [N*AW-1:0] BASES = {32'h0000_3000, 32'h0000_2000, 32'h0001_2000, 32'h0000_0000};
    localparam logic [N*AW-1:0] MASKS = {32'hFFFF_F000, 32'h0000_F000, 32'hFFFF_F000, 32'hFFFF_F000};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    armleo_axi_read_demux_if #(.N(1), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) upstream_axi();
    armleo_axi_read_demux_if #(.N(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) downstream_axi();

    armleo_axi_read_demux #(
        .CLIENT_NUMBER(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW),
        .CLIENT_BASE(BASES), .CLIENT_MASK(MASKS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .upstream_axi(upstream_axi.slave),
        .downstream_axi(downstream_axi.master)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic clear_inputs;
        upstream_axi.arvalid   = 1'b0;
        upstream_axi.araddr    = '0;
        upstream_axi.arlen     = '0;
        upstream_axi.arsize    = 3'd2;
        upstream_axi.arburst   = 2'b01;
        upstream_axi.arid      = '0;
        upstream_axi.arlock    = 1'b0;
        upstream_axi.arprot    = '0;
        upstream_axi.rready    = 1'b0;
        downstream_axi.arready = '0;
        downstream_axi.rvalid  = '0;
        downstream_axi.rresp   = '0;
        downstream_axi.rlast   = '0;
        downstream_axi.rdata   = '0;
        downstream_axi.rid     = '0;
    endtask

    task automatic send_ar(input logic [AW-1:0] addr, input logic [7:0] len, input logic [IW-1:0] id);
        upstream_axi.arvalid = 1'b1;
        upstream_axi.araddr  = addr;
        upstream_axi.arlen   = len;
        upstream_axi.arid    = id;
    endtask

    task automatic set_beat(input int k, input logic v, input logic [DW-1:0] d,
                            input logic [IW-1:0] id, input logic last);
        downstream_axi.rvalid[k]         = v;
        downstream_axi.rdata[k*DW +: DW] = d;
        downstream_axi.rid[k*IW +: IW]   = id;
        downstream_axi.rlast[k]          = last;
        downstream_axi.rresp[k*2 +: 2]   = 2'b00;
    endtask

    task automatic test_reset;
        clear_inputs();
        rst = 1'b1;
        send_ar(32'h2010, 8'd3, 4'd5);
        downstream_axi.arready = '1;
        for (int i = 0; i < 3; i++) begin
            step();
            settle();
            checks++; if (upstream_axi.arready !== 1'b0) $display("FAIL reset_arready: got %b want 0", upstream_axi.arready); else passed++;
            checks++; if (downstream_axi.arvalid !== 4'b0000) $display("FAIL reset_ds_arvalid: got %b want 0000", downstream_axi.arvalid); else passed++;
        end
        checks++; if (upstream_axi.rvalid !== 1'b0) $display("FAIL reset_rvalid: got %b want 0", upstream_axi.rvalid); else passed++;
        step();
        rst = 1'b0;
        upstream_axi.arvalid   = 1'b0;
        downstream_axi.arready = '0;
        settle();
        checks++; if (upstream_axi.rvalid !== 1'b0) $display("FAIL post_reset_rvalid: got %b want 0", upstream_axi.rvalid); else passed++;
        checks++; if (downstream_axi.arvalid !== 4'b0000) $display("FAIL post_reset_ds_arvalid: got %b want 0000", downstream_axi.arvalid); else passed++;
    endtask

    task automatic test_routing;
        send_ar(32'h2010, 8'd3, 4'd5);
        downstream_axi.arready = 4'b0100;
        settle();
        checks++; if (downstream_axi.arvalid !== 4'b0100) $display("FAIL route_ds_arvalid: got %b want 0100", downstream_axi.arvalid); else passed++;
        checks++; if (upstream_axi.arready !== 1'b1) $display("FAIL route_arready: got %b want 1", upstream_axi.arready); else passed++;
        step();
        upstream_axi.arvalid   = 1'b0;
        downstream_axi.arready = '0;
        upstream_axi.rready    = 1'b1;
        for (int b = 0; b < 4; b++) begin
            set_beat(2, 1'b1, 32'hA0 + b, 4'd5, b == 3);
            settle();
            checks++; if (upstream_axi.rdata !== 32'hA0 + b) $display("FAIL route_rdata beat %0d: got %h want %h", b, upstream_axi.rdata, 32'hA0 + b); else passed++;
            checks++; if (upstream_axi.rid !== 4'd5 || upstream_axi.rvalid !== 1'b1) $display("FAIL route_rid beat %0d: got id %h valid %b want 5/1", b, upstream_axi.rid, upstream_axi.rvalid); else passed++;
            checks++; if (upstream_axi.rlast !== (b == 3)) $display("FAIL route_rlast beat %0d: got %b want %b", b, upstream_axi.rlast, b == 3); else passed++;
            checks++; if (downstream_axi.rready !== 4'b0100) $display("FAIL route_ds_rready beat %0d: got %b want 0100", b, downstream_axi.rready); else passed++;
            step();
        end
        set_beat(2, 1'b0, '0, '0, 1'b0);
        settle();
        checks++; if (upstream_axi.rvalid !== 1'b0) $display("FAIL route_idle_rvalid: got %b want 0", upstream_axi.rvalid); else passed++;
        upstream_axi.rready = 1'b0;
    endtask

    task automatic test_decerr;
        send_ar(32'h8000, 8'd2, 4'd9);
        downstream_axi.arready = '0;
        settle();
        checks++; if (upstream_axi.arready !== 1'b1) $display("FAIL decerr_arready: got %b want 1", upstream_axi.arready); else passed++;
        checks++; if (downstream_axi.arvalid !== 4'b0000) $display("FAIL decerr_ds_arvalid: got %b want 0000", downstream_axi.arvalid); else passed++;
        step();
        upstream_axi.arvalid = 1'b0;
        upstream_axi.rready  = 1'b1;
        for (int b = 0; b < 3; b++) begin
            settle();
            checks++; if (upstream_axi.rvalid !== 1'b1 || upstream_axi.rresp !== 2'b11) $display("FAIL decerr_resp beat %0d: got valid %b resp %b want 1/11", b, upstream_axi.rvalid, upstream_axi.rresp); else passed++;
            checks++; if (upstream_axi.rid !== 4'd9 || upstream_axi.rdata !== 32'h0) $display("FAIL decerr_payload beat %0d: got id %h data %h want 9/0", b, upstream_axi.rid, upstream_axi.rdata); else passed++;
            checks++; if (upstream_axi.rlast !== (b == 2)) $display("FAIL decerr_rlast beat %0d: got %b want %b", b, upstream_axi.rlast, b == 2); else passed++;
            step();
        end
        settle();
        checks++; if (upstream_axi.rvalid !== 1'b0) $display("FAIL decerr_idle_rvalid: got %b want 0", upstream_axi.rvalid); else passed++;
        upstream_axi.rready = 1'b0;
    endtask

    task automatic test_backpressure;
        int b;
        logic rr;
        b = 0;
        send_ar(32'h12040, 8'd3, 4'd2);
        downstream_axi.arready = 4'b0010;
        settle();
        checks++; if (downstream_axi.arvalid !== 4'b0010) $display("FAIL bp_ds_arvalid: got %b want 0010", downstream_axi.arvalid); else passed++;
        step();
        upstream_axi.arvalid   = 1'b0;
        downstream_axi.arready = '0;
        for (int c = 0; c < 16 && b < 4; c++) begin
            rr = (c % 2 == 0);
            upstream_axi.rready = rr;
            set_beat(1, 1'b1, 32'hB0 + b, 4'd2, b == 3);
            settle();
            checks++; if (upstream_axi.rdata !== 32'hB0 + b) $display("FAIL bp_rdata cycle %0d: got %h want %h", c, upstream_axi.rdata, 32'hB0 + b); else passed++;
            checks++; if (downstream_axi.rready !== {2'b00, rr, 1'b0}) $display("FAIL bp_ds_rready cycle %0d: got %b want %b", c, downstream_axi.rready, {2'b00, rr, 1'b0}); else passed++;
            if (rr) b++;
            step();
        end
        // Client keeps offering data; the demux must already be back in IDLE.
        set_beat(1, 1'b1, 32'hEE, 4'd2, 1'b1);
        upstream_axi.rready = 1'b1;
        settle();
        checks++; if (upstream_axi.rvalid !== 1'b0) $display("FAIL bp_end_rvalid: got %b want 0", upstream_axi.rvalid); else passed++;
        checks++; if (downstream_axi.rready !== 4'b0000) $display("FAIL bp_end_ds_rready: got %b want 0000", downstream_axi.rready); else passed++;
        set_beat(1, 1'b0, '0, '0, 1'b0);
        upstream_axi.rready = 1'b0;
    endtask

    task automatic test_exclusivity;
        send_ar(32'h3000, 8'd1, 4'd7);
        downstream_axi.arready = 4'b1000;
        settle();
        checks++; if (downstream_axi.arvalid !== 4'b1000) $display("FAIL excl_ds_arvalid: got %b want 1000", downstream_axi.arvalid); else passed++;
        step();
        send_ar(32'h0010, 8'd0, 4'd1);
        downstream_axi.arready = 4'b1001;
        upstream_axi.rready    = 1'b1;
        for (int b = 0; b < 2; b++) begin
            set_beat(0, 1'b1, 32'hDEAD, 4'd1, 1'b1);
            set_beat(3, 1'b1, 32'hC0 + b, 4'd7, b == 1);
            settle();
            checks++; if (upstream_axi.rdata !== 32'hC0 + b || upstream_axi.rid !== 4'd7) $display("FAIL excl_rdata beat %0d: got %h id %h want %h id 7", b, upstream_axi.rdata, upstream_axi.rid, 32'hC0 + b); else passed++;
            checks++; if (downstream_axi.rready !== 4'b1000) $display("FAIL excl_ds_rready beat %0d: got %b want 1000", b, downstream_axi.rready); else passed++;
            checks++; if (upstream_axi.arready !== 1'b0 || downstream_axi.arvalid !== 4'b0000) $display("FAIL excl_ar_blocked beat %0d: got arready %b arvalid %b want 0/0000", b, upstream_axi.arready, downstream_axi.arvalid); else passed++;
            step();
        end
        set_beat(3, 1'b0, '0, '0, 1'b0);
        settle();
        checks++; if (downstream_axi.arvalid !== 4'b0001 || upstream_axi.arready !== 1'b1) $display("FAIL excl_second_ar: got arvalid %b arready %b want 0001/1", downstream_axi.arvalid, upstream_axi.arready); else passed++;
        checks++; if (upstream_axi.rvalid !== 1'b0) $display("FAIL excl_gap_rvalid: got %b want 0", upstream_axi.rvalid); else passed++;
        step();
        upstream_axi.arvalid   = 1'b0;
        downstream_axi.arready = '0;
        settle();
        checks++; if (upstream_axi.rdata !== 32'hDEAD || upstream_axi.rid !== 4'd1 || upstream_axi.rlast !== 1'b1) $display("FAIL excl_second_beat: got %h id %h last %b want dead id 1 last 1", upstream_axi.rdata, upstream_axi.rid, upstream_axi.rlast); else passed++;
        step();
        set_beat(0, 1'b0, '0, '0, 1'b0);
        upstream_axi.rready = 1'b0;
    endtask

    task automatic test_max_len;
        int cnt;
        int bad;
        logic done;
        cnt = 0;
        bad = 0;
        done = 1'b0;
        send_ar(32'h8000, 8'd255, 4'd3);
        settle();
        checks++; if (upstream_axi.arready !== 1'b1) $display("FAIL maxlen_arready: got %b want 1", upstream_axi.arready); else passed++;
        step();
        upstream_axi.arvalid = 1'b0;
        upstream_axi.rready  = 1'b1;
        for (int c = 0; c < 300 && !done; c++) begin
            settle();
            if (upstream_axi.rvalid !== 1'b1 || upstream_axi.rresp !== 2'b11 || upstream_axi.rid !== 4'd3) bad++;
            cnt++;
            if (upstream_axi.rlast === 1'b1) done = 1'b1;
            step();
        end
        checks++; if (cnt !== 256 || done !== 1'b1) $display("FAIL maxlen_beats: got %0d beats (rlast seen %b) want 256", cnt, done); else passed++;
        checks++; if (bad !== 0) $display("FAIL maxlen_payload: got %0d bad beats want 0", bad); else passed++;
        settle();
        checks++; if (upstream_axi.rvalid !== 1'b0) $display("FAIL maxlen_idle_rvalid: got %b want 0", upstream_axi.rvalid); else passed++;
        upstream_axi.rready = 1'b0;
    endtask

    task automatic test_overlap;
        send_ar(32'h12000, 8'd0, 4'd4);
        downstream_axi.arready = 4'b0000;
        settle();
        checks++; if (downstream_axi.arvalid !== 4'b0010) $display("FAIL overlap_ds_arvalid: got %b want 0010", downstream_axi.arvalid); else passed++;
        checks++; if (upstream_axi.arready !== 1'b0) $display("FAIL overlap_wait_arready: got %b want 0", upstream_axi.arready); else passed++;
        downstream_axi.arready = 4'b0110;
        settle();
        checks++; if (upstream_axi.arready !== 1'b1) $display("FAIL overlap_arready: got %b want 1", upstream_axi.arready); else passed++;
        step();
        upstream_axi.arvalid   = 1'b0;
        downstream_axi.arready = '0;
        upstream_axi.rready    = 1'b1;
        set_beat(1, 1'b1, 32'h77, 4'd4, 1'b1);
        set_beat(2, 1'b1, 32'h88, 4'd4, 1'b1);
        settle();
        checks++; if (upstream_axi.rdata !== 32'h77) $display("FAIL overlap_rdata: got %h want 77", upstream_axi.rdata); else passed++;
        checks++; if (downstream_axi.rready !== 4'b0010) $display("FAIL overlap_ds_rready: got %b want 0010", downstream_axi.rready); else passed++;
        step();
        set_beat(1, 1'b0, '0, '0, 1'b0);
        set_beat(2, 1'b0, '0, '0, 1'b0);
        upstream_axi.rready = 1'b0;
    endtask

    task automatic test_reset_mid_burst;
        send_ar(32'h8000, 8'd5, 4'd6);
        settle();
        step();
        upstream_axi.arvalid = 1'b0;
        settle();
        checks++; if (upstream_axi.rvalid !== 1'b1) $display("FAIL midrst_before: got %b want 1", upstream_axi.rvalid); else passed++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        settle();
        checks++; if (upstream_axi.rvalid !== 1'b0) $display("FAIL midrst_after: got %b want 0", upstream_axi.rvalid); else passed++;
    endtask

    initial begin
        test_reset();
        test_routing();
        test_decerr();
        test_backpressure();
        test_exclusivity();
        test_max_len();
        test_overlap();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
